conbus_rr: RTL

//  Parametrised successor of the fixed 6x6 Wishbone shared-bus switch. Connects NM masters to NS slaves.
//  - Fair round-robin arbitration between masters.
//  - Address decode on the top DEC_W address bits; the slave map is a parameter, not a port list.
//  - Bus-error response for unmapped addresses.
//  - Watchdog timeout that terminates hung slave cycles with err.
//  - Sits between the LM32 I/D buses (plus DMA masters) and BRAM/SRAM/CSR bridge/TDC.

---
 rtl/conbus_rr_pkg.sv | 16 +
 rtl/conbus_rr_if.sv | 41 ++++
 rtl/conbus_rr_arbiter.sv | 59 +++++
 rtl/conbus_rr.sv | 117 +++++++++++
 4 files changed

// File: rtl/conbus_rr_pkg.sv
// Shared constants and types for the round-robin shared-bus switch.
package conbus_rr_pkg;

  localparam int unsigned WB_AW = 32;
  localparam int unsigned WB_DW = 32;

  typedef enum logic [2:0] {
    CtiClassic = 3'b000,
    CtiIncr    = 3'b010,
    CtiEnd     = 3'b111
  } cti_e;

  // Default six-slave map, slave i at [i*3 +: 3]: BRAM, CSR, SRAM, DMA, TDC, spare
  localparam logic [17:0] DefSAddr = {3'b110, 3'b101, 3'b100, 3'b010, 3'b001, 3'b000};

endpackage

// File: rtl/conbus_rr_if.sv
// Bundled master-side and slave-side Wishbone signals of the switch.
// slave: the switch's own view; master: the environment driving the switch.
interface conbus_rr_if #(
  parameter int unsigned NM = 6,
  parameter int unsigned NS = 6
);
  import conbus_rr_pkg::*;

  logic [NM*WB_AW-1:0] m_adr_i;
  logic [NM*WB_DW-1:0] m_dat_i;
  logic [NM*4-1:0]     m_sel_i;
  logic [NM*3-1:0]     m_cti_i;
  logic [NM-1:0]       m_we_i;
  logic [NM-1:0]       m_cyc_i;
  logic [NM-1:0]       m_stb_i;
  logic [WB_DW-1:0]    m_dat_o;
  logic [NM-1:0]       m_ack_o;
  logic [NM-1:0]       m_err_o;
  logic [WB_AW-1:0]    s_adr_o;
  logic [WB_DW-1:0]    s_dat_o;
  logic [3:0]          s_sel_o;
  logic [2:0]          s_cti_o;
  logic                s_we_o;
  logic [NS-1:0]       s_cyc_o;
  logic [NS-1:0]       s_stb_o;
  logic [NS*WB_DW-1:0] s_dat_i;
  logic [NS-1:0]       s_ack_i;

  modport slave (
    input  m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_we_i, m_cyc_i, m_stb_i, s_dat_i, s_ack_i,
    output m_dat_o, m_ack_o, m_err_o, s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_we_o,
           s_cyc_o, s_stb_o
  );

  modport master (
    output m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_we_i, m_cyc_i, m_stb_i, s_dat_i, s_ack_i,
    input  m_dat_o, m_ack_o, m_err_o, s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_we_o,
           s_cyc_o, s_stb_o
  );

endinterface

// File: rtl/conbus_rr_arbiter.sv
// Round-robin owner selection: regrants only when there is no owner or the owner drops cyc.
module conbus_rr_arbiter #(
  parameter int unsigned NM = 6,
  parameter int unsigned OW = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic [NM-1:0] req_i,
  output logic [OW-1:0] own_o,
  output logic          own_v_o
);

  logic [OW-1:0] own_q, own_d;
  logic          own_v_q, own_v_d;
  // Set until the first grant after reset so master 0 is scanned first, not last.
  logic          fresh_q, fresh_d;

  // Next owner: scan from own+1 (own itself after reset), previous owner last.
  always_comb begin
    logic [31:0]     start;
    logic [31:0]     sum;
    logic [2*NM-1:0] rot;
    own_d   = own_q;
    own_v_d = own_v_q;
    fresh_d = fresh_q;
    start   = 32'(own_q) + {31'b0, ~fresh_q};
    rot     = {req_i, req_i} >> start;
    sum     = '0;
    if (!own_v_q || !req_i[own_q]) begin
      own_v_d = 1'b0;
      for (int i = 0; i < NM; i++) begin
        if (!own_v_d && rot[i]) begin
          sum     = start + 32'(i);
          if (sum >= NM) sum = sum - NM;
          own_d   = OW'(sum);
          own_v_d = 1'b1;
          fresh_d = 1'b0;
        end
      end
    end
  end

  // Owner state registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      own_q   <= '0;
      own_v_q <= 1'b0;
      fresh_q <= 1'b1;
    end else begin
      own_q   <= own_d;
      own_v_q <= own_v_d;
      fresh_q <= fresh_d;
    end
  end

  assign own_o   = own_q;
  assign own_v_o = own_v_q;

endmodule

// File: rtl/conbus_rr.sv
// NM x NS shared-bus Wishbone switch: round-robin grant, parametric decode,
// unmapped-address bus error and a watchdog that terminates hung slave cycles.
module conbus_rr import conbus_rr_pkg::*; #(
  parameter int unsigned         NM      = 6,
  parameter int unsigned         NS      = 6,
  parameter int unsigned         DEC_W   = 3,
  parameter logic [NS*DEC_W-1:0] S_ADDR  = DefSAddr,
  parameter logic [NS-1:0]       S_EN    = '1,
  parameter int unsigned         TIMEOUT = 1023
) (
  input logic       sys_clk,
  input logic       sys_rst,
  conbus_rr_if.slave bus
);

  localparam int unsigned OW = (NM > 1) ? $clog2(NM) : 1;
  localparam int unsigned WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] WdLast = WW'(TIMEOUT - 1);

  logic [OW-1:0]    own;
  logic             own_v;
  logic [WB_AW-1:0] adr;
  logic             cyc_own, stb_own;
  logic [NS-1:0]    hit;
  logic             hit_any, ack, unmapped, wd_fire;
  logic             err_q, err_d, arm_q, arm_d;
  logic [WW-1:0]    wdog_q, wdog_d;

  conbus_rr_arbiter #(.NM(NM), .OW(OW)) u_arb (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .req_i   (bus.m_cyc_i),
    .own_o   (own),
    .own_v_o (own_v)
  );

  // Owner datapath mux; everything reads 0 while nobody owns the bus.
  always_comb begin
    adr         = '0;
    bus.s_dat_o = '0;
    bus.s_sel_o = '0;
    bus.s_cti_o = '0;
    bus.s_we_o  = 1'b0;
    cyc_own     = 1'b0;
    stb_own     = 1'b0;
    for (int k = 0; k < NM; k++) begin
      if (own_v && own == OW'(k)) begin
        adr         = bus.m_adr_i[k*WB_AW +: WB_AW];
        bus.s_dat_o = bus.m_dat_i[k*WB_DW +: WB_DW];
        bus.s_sel_o = bus.m_sel_i[k*4 +: 4];
        bus.s_cti_o = bus.m_cti_i[k*3 +: 3];
        bus.s_we_o  = bus.m_we_i[k];
        cyc_own     = bus.m_cyc_i[k];
        stb_own     = bus.m_cyc_i[k] & bus.m_stb_i[k];
      end
    end
  end

  // Address decode, one-hot with the lowest slave index winning duplicate maps.
  always_comb begin
    hit     = '0;
    hit_any = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (!hit_any && S_EN[i] && adr[WB_AW-1 -: DEC_W] == S_ADDR[i*DEC_W +: DEC_W]) begin
        hit[i]  = 1'b1;
        hit_any = 1'b1;
      end
    end
  end

  // Slave strobes and return path; acks only count while the owner still holds cyc.
  always_comb begin
    bus.s_cyc_o = hit & {NS{cyc_own}};
    bus.s_stb_o = hit & {NS{stb_own}};
    bus.m_dat_o = '0;
    ack         = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (hit[i]) begin
        bus.m_dat_o = bus.s_dat_i[i*WB_DW +: WB_DW];
        ack         = cyc_own & bus.s_ack_i[i];
      end
    end
    for (int k = 0; k < NM; k++) begin
      bus.m_ack_o[k] = ack & (own == OW'(k));
      bus.m_err_o[k] = own_v & err_q & (own == OW'(k));
    end
  end

  // Error sources: one-shot unmapped error (re-armed by an idle stb cycle) and watchdog expiry.
  always_comb begin
    unmapped = stb_own & ~hit_any;
    wd_fire  = (TIMEOUT != 0) && stb_own && hit_any && !ack && !err_q && (wdog_q == WdLast);
    err_d    = (unmapped & arm_q) | wd_fire;
    arm_d    = !stb_own ? 1'b1 : ((unmapped & arm_q) ? 1'b0 : arm_q);
    if (TIMEOUT == 0 || !stb_own || !hit_any || ack || err_q || wd_fire) begin
      wdog_d = '0;
    end else begin
      wdog_d = wdog_q + WW'(1);
    end
  end

  // Error and watchdog registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      err_q  <= 1'b0;
      arm_q  <= 1'b1;
      wdog_q <= '0;
    end else begin
      err_q  <= err_d;
      arm_q  <= arm_d;
      wdog_q <= wdog_d;
    end
  end

  assign bus.s_adr_o = adr;

endmodule
